dcache_wb_ctrl: RTL and testbench

Write-back drain controller for the dcache write FIFO. Each cycle the FIFO reports a pending line, this block pops it with a one-cycle accept pulse and latches the line. It then sequences that line onto the AXI write channels as one INCR burst (AW, then W beats, then B). It serialises write-backs to one outstanding burst and reports bus errors and drain status to the cache controller.

---
 rtl/dcache_wb_ctrl.sv | 131 +++++++++++++
 tb/tb_dcache_wb_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_ctrl.sv
// Write-back drain controller: pops one dcache write-FIFO line at a time and
// issues it as a single AXI INCR burst (AW, W beats, B), tracking bus errors.
module dcache_wb_ctrl #(
    parameter int unsigned DCACHELINE_WIDTH = 128,
    parameter int unsigned AXI_DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_wen_i,
    input  logic [DCACHELINE_WIDTH-1:0]   fifo_wdata_i,
    input  logic [ADDR_WIDTH-1:0]         fifo_awaddr_i,
    output logic                          fifo_accept_o,
    output logic                          awvalid_o,
    input  logic                          awready_i,
    output logic [ADDR_WIDTH-1:0]         awaddr_o,
    output logic [7:0]                    awlen_o,
    output logic [2:0]                    awsize_o,
    output logic [1:0]                    awburst_o,
    output logic                          wvalid_o,
    input  logic                          wready_i,
    output logic [AXI_DATA_WIDTH-1:0]     wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   wstrb_o,
    output logic                          wlast_o,
    input  logic                          bvalid_i,
    output logic                          bready_o,
    input  logic [1:0]                    bresp_i,
    output logic                          busy_o,
    output logic                          drained_o,
    output logic                          err_o,
    output logic [ADDR_WIDTH-1:0]         err_addr_o,
    input  logic                          err_clr_i
);
    localparam int unsigned BEATS  = DCACHELINE_WIDTH / AXI_DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(BEATS) + 1;
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(DCACHELINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t                        state;
    logic [CNT_W-1:0]              beat_cnt;
    logic [DCACHELINE_WIDTH-1:0]   line_q;
    logic [ADDR_WIDTH-1:0]         addr_q;
    logic                          b_hs;

    assign b_hs          = bready_o & bvalid_i;
    assign fifo_accept_o = (state == S_IDLE) & fifo_wen_i & rst;
    assign drained_o     = (state == S_IDLE) & ~fifo_wen_i;
    assign awaddr_o      = addr_q;
    assign awlen_o       = 8'(BEATS - 1);
    assign awsize_o      = 3'($clog2(STRB_W));
    assign awburst_o     = 2'b01;
    assign wstrb_o       = '1;

    // Beat 0 comes from the line LSBs.
    always_comb begin
        wdata_o = line_q[AXI_DATA_WIDTH-1:0];
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat_cnt == CNT_W'(i)) wdata_o = line_q[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        end
    end

    // Burst sequencer; handshake outputs are flops updated alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            beat_cnt   <= '0;
            line_q     <= '0;
            addr_q     <= '0;
            awvalid_o  <= 1'b0;
            wvalid_o   <= 1'b0;
            wlast_o    <= 1'b0;
            bready_o   <= 1'b0;
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (fifo_wen_i) begin
                        line_q    <= fifo_wdata_i;
                        addr_q    <= fifo_awaddr_i & ALIGN_MASK;
                        awvalid_o <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= S_AW;
                    end
                end
                S_AW: begin
                    if (awready_i) begin
                        beat_cnt  <= '0;
                        awvalid_o <= 1'b0;
                        wvalid_o  <= 1'b1;
                        wlast_o   <= (BEATS == 1);
                        state     <= S_W;
                    end
                end
                S_W: begin
                    if (wready_i) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (wlast_o) begin
                            wvalid_o <= 1'b0;
                            wlast_o  <= 1'b0;
                            bready_o <= 1'b1;
                            state    <= S_B;
                        end else begin
                            wlast_o <= ((beat_cnt + CNT_W'(1)) == CNT_W'(BEATS - 1));
                        end
                    end
                end
                S_B: begin
                    if (bvalid_i) begin
                        bready_o <= 1'b0;
                        busy_o   <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A failing response beats a simultaneous clear; only the first address is kept.
            if (b_hs && (bresp_i != 2'b00)) begin
                err_o <= 1'b1;
                if (!err_o) err_addr_o <= addr_q;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Bench for dcache_wb_ctrl: FIFO/AXI-slave stimulus with a handshake-count
// reference model, plus a BEATS=1 instance for the single-beat case.
`timescale 1ns/1ps
module tb_dcache_wb_ctrl;
    localparam int unsigned LW = 128;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NB = LW / DW;
    localparam int unsigned SW = DW / 8;
    localparam logic [AW-1:0] ALIGN  = ~AW'(LW / 8 - 1);
    localparam logic [AW-1:0] ALIGN1 = ~AW'(DW / 8 - 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance (BEATS=4)
    logic          fifo_wen_i, fifo_accept_o, awvalid_o, awready_i, wvalid_o, wready_i, wlast_o;
    logic [LW-1:0] fifo_wdata_i;
    logic [AW-1:0] fifo_awaddr_i, awaddr_o, err_addr_o;
    logic [7:0]    awlen_o;
    logic [2:0]    awsize_o;
    logic [1:0]    awburst_o, bresp_i;
    logic [DW-1:0] wdata_o;
    logic [SW-1:0] wstrb_o;
    logic          bvalid_i, bready_o, busy_o, drained_o, err_o, err_clr_i;

    dcache_wb_ctrl #(.DCACHELINE_WIDTH(LW), .AXI_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .rst(rst),
        .fifo_wen_i(fifo_wen_i), .fifo_wdata_i(fifo_wdata_i), .fifo_awaddr_i(fifo_awaddr_i),
        .fifo_accept_o(fifo_accept_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
        .awsize_o(awsize_o), .awburst_o(awburst_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
        .busy_o(busy_o), .drained_o(drained_o), .err_o(err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
    );

    // Single-beat instance (line == one AXI word)
    logic          f1_wen, f1_accept, aw1_valid, w1_valid, w1_last, b1_ready, busy1, drained1, err1;
    logic [DW-1:0] f1_data, w1_data;
    logic [AW-1:0] f1_addr, aw1_addr, err1_addr;
    logic [7:0]    aw1_len;
    logic [2:0]    aw1_size;
    logic [1:0]    aw1_burst;
    logic [SW-1:0] w1_strb;

    dcache_wb_ctrl #(.DCACHELINE_WIDTH(DW), .AXI_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut1 (
        .clk(clk), .rst(rst),
        .fifo_wen_i(f1_wen), .fifo_wdata_i(f1_data), .fifo_awaddr_i(f1_addr), .fifo_accept_o(f1_accept),
        .awvalid_o(aw1_valid), .awready_i(1'b1), .awaddr_o(aw1_addr), .awlen_o(aw1_len),
        .awsize_o(aw1_size), .awburst_o(aw1_burst),
        .wvalid_o(w1_valid), .wready_i(1'b1), .wdata_o(w1_data), .wstrb_o(w1_strb), .wlast_o(w1_last),
        .bvalid_i(1'b1), .bready_o(b1_ready), .bresp_i(2'b00),
        .busy_o(busy1), .drained_o(drained1), .err_o(err1), .err_addr_o(err1_addr), .err_clr_i(1'b0)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic chk_on = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Bench-owned FIFO contents and reference model (counts of completed handshakes)
    logic [AW-1:0] q_addr[$];
    logic [LW-1:0] q_line[$];
    logic          m_busy = 1'b0, m_aw_done = 1'b0, m_err = 1'b0;
    int            m_beats = 0;
    logic [AW-1:0] m_addr = '0, m_err_addr = '0;
    logic [LW-1:0] m_line = '0;

    always @(negedge rst) begin
        m_busy = 1'b0; m_aw_done = 1'b0; m_beats = 0; m_err = 1'b0; m_err_addr = '0;
    end

    always @(posedge clk) begin
        logic b_done;
        if (rst && chk_on) begin
            b_done = 1'b0;
            if (!m_busy) begin
                if (q_addr.size() != 0) begin
                    m_addr = q_addr.pop_front() & ALIGN;
                    m_line = q_line.pop_front();
                    m_busy = 1'b1; m_aw_done = 1'b0; m_beats = 0;
                end
            end else if (!m_aw_done) begin
                if (awready_i) m_aw_done = 1'b1;
            end else if (m_beats < NB) begin
                if (wready_i) m_beats++;
            end else if (bvalid_i) begin
                b_done = 1'b1;
                m_busy = 1'b0;
            end
            if (b_done && bresp_i != 2'b00) begin
                if (!m_err) m_err_addr = m_addr;
                m_err = 1'b1;
            end else if (err_clr_i) begin
                m_err = 1'b0;
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        logic ev, ew;
        if (chk_on) begin
            ev = m_busy && !m_aw_done;
            ew = m_busy && m_aw_done && (m_beats < NB);
            chk("accept",   fifo_accept_o, rst && !m_busy && q_addr.size() != 0);
            chk("awvalid",  awvalid_o, ev);
            chk("wvalid",   wvalid_o, ew);
            chk("wlast",    wlast_o, ew && (m_beats == NB - 1));
            chk("bready",   bready_o, m_busy && (m_beats == NB));
            chk("busy",     busy_o, m_busy);
            chk("drained",  drained_o, !m_busy && q_addr.size() == 0);
            chk("err",      err_o, m_err);
            chk("err_addr", err_addr_o, m_err_addr);
            chk("awburst",  awburst_o, 2'b01);
            if (ev) begin
                chk("awaddr", awaddr_o, m_addr);
                chk("awlen",  awlen_o, NB - 1);
                chk("awsize", awsize_o, $clog2(SW));
            end
            if (ew) begin
                chk("wdata", wdata_o, m_line[m_beats*DW +: DW]);
                chk("wstrb", wstrb_o, {SW{1'b1}});
            end
        end
    end

    // Handshake monitors feeding the literal checks
    int            acc_cyc[$], aw_cyc[$], b_cyc[$];
    logic [AW-1:0] mon_aw[$];
    logic [DW-1:0] mon_w[$];
    logic          mon_wl[$];
    int            acc1[$], b1c[$];
    logic [DW-1:0] w1q[$];
    logic          wl1q[$];
    logic [AW-1:0] aw1q[$];
    logic [7:0]    awlen1q[$];
    logic          pop1 = 1'b0;

    always @(negedge clk) begin
        if (fifo_accept_o) acc_cyc.push_back(cyc);
        if (awvalid_o && awready_i) begin aw_cyc.push_back(cyc); mon_aw.push_back(awaddr_o); end
        if (wvalid_o && wready_i) begin mon_w.push_back(wdata_o); mon_wl.push_back(wlast_o); end
        if (bvalid_i && bready_o) b_cyc.push_back(cyc);
        if (f1_accept) begin acc1.push_back(cyc); pop1 = 1'b1; end
        if (aw1_valid) begin aw1q.push_back(aw1_addr); awlen1q.push_back(aw1_len); end
        if (w1_valid) begin w1q.push_back(w1_data); wl1q.push_back(w1_last); end
        if (b1_ready) b1c.push_back(cyc);
    end

    task automatic clear_mon();
        acc_cyc.delete(); aw_cyc.delete(); b_cyc.delete(); mon_aw.delete(); mon_w.delete(); mon_wl.delete();
    endtask

    // Stimulus knobs: 0 ready slave, 1 scripted stalls, 2 random
    int            mode = 0;
    logic [1:0]    bresp_knob = 2'b00;
    logic          clr_knob = 1'b0;
    int            aw_wait = 0, w_wait = 0;
    logic [AW-1:0] q1_addr[$];
    logic [DW-1:0] q1_line[$];

    task automatic push(input logic [AW-1:0] a, input logic [LW-1:0] d);
        q_addr.push_back(a); q_line.push_back(d);
    endtask

    task automatic drive();
        if (m_busy && !m_aw_done) aw_wait++; else aw_wait = 0;
        if (m_busy && m_aw_done && m_beats == 2) w_wait++; else w_wait = 0;
        case (mode)
            1: begin
                awready_i = (aw_wait > 5);
                wready_i  = !(w_wait >= 1 && w_wait <= 3);
                bvalid_i  = 1'b1;
                bresp_i   = bresp_knob;
                err_clr_i = clr_knob;
            end
            2: begin
                if ($urandom_range(0, 3) == 0 && q_addr.size() < 4)
                    push($urandom, {$urandom, $urandom, $urandom, $urandom});
                awready_i = 1'($urandom_range(0, 1));
                wready_i  = 1'($urandom_range(0, 1));
                bvalid_i  = 1'($urandom_range(0, 1));
                bresp_i   = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
                err_clr_i = ($urandom_range(0, 15) == 0);
            end
            default: begin
                awready_i = 1'b1; wready_i = 1'b1; bvalid_i = 1'b1;
                bresp_i = bresp_knob; err_clr_i = clr_knob;
            end
        endcase
        fifo_wen_i    = (q_addr.size() != 0);
        fifo_awaddr_i = fifo_wen_i ? q_addr[0] : '0;
        fifo_wdata_i  = fifo_wen_i ? q_line[0] : '0;
        if (pop1 && q1_addr.size() != 0) begin q1_addr.delete(0); q1_line.delete(0); end
        pop1    = 1'b0;
        f1_wen  = (q1_addr.size() != 0);
        f1_addr = f1_wen ? q1_addr[0] : '0;
        f1_data = f1_wen ? q1_line[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        drive();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((m_busy || q_addr.size() != 0) && n < max_cyc) begin tick(); n++; end
        if (m_busy || q_addr.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: timeout after %0d cycles, want idle", max_cyc);
        end
    endtask

    initial begin
        fifo_wen_i = 0; fifo_wdata_i = '0; fifo_awaddr_i = '0; awready_i = 0; wready_i = 0;
        bvalid_i = 0; bresp_i = 0; err_clr_i = 0; f1_wen = 0; f1_data = '0; f1_addr = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        chk_on = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_awvalid", awvalid_o, 0);
        chk("rst_err_addr", err_addr_o, 0);
        chk("rst_drained", drained_o, 1);
        rst = 1'b1;
        repeat (2) tick();

        // Single line, ready slave
        clear_mon();
        push(32'h1000_0013, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
        drive();
        wait_idle(50);
        chk("t1_accepts", acc_cyc.size(), 1);
        chk("t1_awaddr", mon_aw[0], 32'h1000_0010);
        chk("t1_nbeats", mon_w.size(), 4);
        chk("t1_w0", mon_w[0], 32'h1111_1111);
        chk("t1_w1", mon_w[1], 32'h2222_2222);
        chk("t1_w2", mon_w[2], 32'h3333_3333);
        chk("t1_w3", mon_w[3], 32'h4444_4444);
        chk("t1_wlast", {mon_wl[0], mon_wl[1], mon_wl[2], mon_wl[3]}, 4'b0001);
        chk("t1_b_latency", b_cyc[0] - acc_cyc[0], 6);

        // Three queued lines, back to back
        clear_mon();
        push(32'h2000_0000, {4{32'hA0A0_0001}});
        push(32'h2000_0045, {4{32'hA0A0_0002}});
        push(32'h2000_008F, {4{32'hA0A0_0003}});
        drive();
        wait_idle(100);
        chk("t2_accepts", acc_cyc.size(), 3);
        chk("t2_gap01", acc_cyc[1] - acc_cyc[0], 7);
        chk("t2_gap12", acc_cyc[2] - acc_cyc[1], 7);
        chk("t2_aw1", mon_aw[1], 32'h2000_0040);
        chk("t2_aw2", mon_aw[2], 32'h2000_0080);
        chk("t2_bcount", b_cyc.size(), 3);
        chk("t2_drained", drained_o, 1);

        // AW and W stalls
        clear_mon();
        mode = 1;
        push(32'h4000_0020, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
        push(32'h4000_0031, {4{32'h5A5A_5A5A}});
        drive();
        wait_idle(200);
        chk("t3_aw_delay", aw_cyc[0] - acc_cyc[0], 6);
        chk("t3_b_latency", b_cyc[0] - acc_cyc[0], 14);
        chk("t3_next_accept", acc_cyc[1] - b_cyc[0], 1);
        chk("t3_w0", mon_w[0], 32'hAAAA_AAAA);
        chk("t3_w1", mon_w[1], 32'hBBBB_BBBB);
        chk("t3_w2", mon_w[2], 32'hCCCC_CCCC);
        chk("t3_w3", mon_w[3], 32'hDDDD_DDDD);
        mode = 0;

        // Error capture, sticky address, clear
        push(32'h5000_0000, {4{32'h1}});
        drive(); wait_idle(50);
        chk("t4_noerr", err_o, 0);
        bresp_knob = 2'b10;
        push(32'h5000_0048, {4{32'h2}});
        drive(); wait_idle(50);
        chk("t4_err", err_o, 1);
        chk("t4_err_addr", err_addr_o, 32'h5000_0040);
        bresp_knob = 2'b11;
        push(32'h5000_0080, {4{32'h3}});
        drive(); wait_idle(50);
        chk("t4_err_addr_held", err_addr_o, 32'h5000_0040);
        bresp_knob = 2'b00;
        clr_knob = 1'b1;
        tick();
        clr_knob = 1'b0;
        tick();
        chk("t4_cleared", err_o, 0);
        chk("t4_addr_after_clr", err_addr_o, 32'h5000_0040);

        // Reset during W beat 1
        push(32'h6000_0000, {4{32'h6}});
        drive();
        for (int i = 0; i < 20 && !(m_busy && m_aw_done && m_beats == 1); i++) tick();
        chk("t5_reached_beat1", m_beats, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_awvalid", awvalid_o, 0);
        chk("t5_wvalid", wvalid_o, 0);
        chk("t5_bready", bready_o, 0);
        chk("t5_busy", busy_o, 0);
        chk("t5_err_addr", err_addr_o, 0);
        repeat (2) tick();
        rst = 1'b1;
        clear_mon();
        push(32'h6000_0017, {4{32'h7}});
        drive(); wait_idle(50);
        chk("t5_accepts", acc_cyc.size(), 1);
        chk("t5_awaddr", mon_aw[0], 32'h6000_0010);
        chk("t5_nbeats", mon_w.size(), 4);

        // Single-beat line instance
        q1_addr.push_back(32'h3000_0007); q1_line.push_back(32'hCAFE_0001);
        q1_addr.push_back(32'h3000_000A); q1_line.push_back(32'hCAFE_0002);
        drive();
        repeat (12) tick();
        chk("b1_accepts", acc1.size(), 2);
        chk("b1_gap", acc1[1] - acc1[0], 4);
        chk("b1_b_latency", b1c[0] - acc1[0], 3);
        chk("b1_aw0", aw1q[0], 32'h3000_0007 & ALIGN1);
        chk("b1_aw1", aw1q[1], 32'h3000_0008);
        chk("b1_awlen", awlen1q[0], 0);
        chk("b1_nbeats", w1q.size(), 2);
        chk("b1_w0", w1q[0], 32'hCAFE_0001);
        chk("b1_w1", w1q[1], 32'hCAFE_0002);
        chk("b1_wlast", {wl1q[0], wl1q[1]}, 2'b11);
        chk("b1_drained", drained1, 1);

        // Randomised traffic
        mode = 2;
        repeat (3000) tick();
        mode = 0;
        wait_idle(200);
        chk("rand_drained", drained_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
